// File: rtl/uart_rx_frame_checker.sv
// uart_rx_frame_checker
// Assembles one UART frame from the mid-bit sample stream delivered by the RX
// baud sampler: start bit, DATA_W data bits LSB first, an optional parity bit
// and STOP_BITS stop bits. It checks parity against a per-frame mode and checks
// every stop bit. The received word is presented with a one-cycle valid strobe
// and per-frame error flags. Two saturating error counters feed the status
// registers.
//
// Handshake: bit_valid is a one-cycle qualifier on bit_in. Only cycles with
// bit_valid=1 advance the frame FSM, and every other cycle holds all frame
// state. data_valid is a one-cycle pulse with no ready/back-pressure, so the
// consumer must capture data_out, parity_error and framing_error in the cycle
// data_valid is high. Those three outputs hold until the next completion.
//
// fsm_state exposes the frame FSM encoding (0 IDLE, 1 DATA, 2 PARITY, 3 STOP)
// so that external checkers can observe it.

module uart_rx_frame_checker #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int CNT_W     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic [1:0]        parity_mode,
  input  logic              cnt_clear,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_error,
  output logic              framing_error,
  output logic              busy,
  output logic [CNT_W-1:0]  parity_err_cnt,
  output logic [CNT_W-1:0]  framing_err_cnt,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // The bit counter must reach DATA_W-1 in DATA and STOP_BITS-1 in STOP.
  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  state_t            state;
  logic [DATA_W-1:0] shift_q;
  logic [BCW-1:0]    bit_cnt;
  logic [1:0]        mode_q;
  logic              par_err_q;
  logic              fr_err_q;

  logic              parity_on;
  logic              data_xor;
  logic              exp_par;
  logic              frame_done;
  logic              final_fr_err;

  // Modes 01 (even) and 10 (odd) carry a parity slot. Modes 00 and 11 do not.
  // The XOR of the two mode bits is 1 exactly for the two parity modes.
  assign parity_on    = ^mode_q;
  assign data_xor     = ^shift_q;
  assign exp_par      = (mode_q == 2'b10) ? ~data_xor : data_xor;
  assign frame_done   = bit_valid && (state == STOP) && (bit_cnt == LAST_STOP);
  assign final_fr_err = fr_err_q | ~bit_in;
  assign fsm_state    = state;

  // Frame FSM: sample acceptance, shifting, error capture and completion outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      shift_q       <= '0;
      bit_cnt       <= '0;
      mode_q        <= 2'b00;
      par_err_q     <= 1'b0;
      fr_err_q      <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (bit_valid) begin
        case (state)
          IDLE: begin
            // A low sample while idle is a start bit. A high sample is line idle.
            if (!bit_in) begin
              mode_q    <= parity_mode;
              bit_cnt   <= '0;
              par_err_q <= 1'b0;
              fr_err_q  <= 1'b0;
              busy      <= 1'b1;
              state     <= DATA;
            end
          end

          DATA: begin
            // Shifting in at the MSB lands the first data bit at bit 0.
            shift_q <= {bit_in, shift_q[DATA_W-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= parity_on ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end

          PARITY: begin
            if (bit_in != exp_par) begin
              par_err_q <= 1'b1;
            end
            bit_cnt <= '0;
            state   <= STOP;
          end

          STOP: begin
            // Every stop sample is consumed, even after a bad one.
            if (!bit_in) begin
              fr_err_q <= 1'b1;
            end
            if (bit_cnt == LAST_STOP) begin
              state         <= IDLE;
              busy          <= 1'b0;
              bit_cnt       <= '0;
              data_valid    <= 1'b1;
              data_out      <= par_err_q ? '0 : shift_q;
              parity_error  <= par_err_q;
              framing_error <= final_fr_err;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating error counters. A clear wins over an increment on the same edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      parity_err_cnt  <= '0;
      framing_err_cnt <= '0;
    end else if (cnt_clear) begin
      parity_err_cnt  <= '0;
      framing_err_cnt <= '0;
    end else begin
      if (frame_done && par_err_q && (parity_err_cnt != '1)) begin
        parity_err_cnt <= parity_err_cnt + CNT_W'(1);
      end
      if (frame_done && final_fr_err && (framing_err_cnt != '1)) begin
        framing_err_cnt <= framing_err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Bench for uart_rx_frame_checker.
// The bench instantiates two devices. Device 0 uses one stop bit and device 1
// uses two stop bits. Both use 8 data bits and 8-bit counters.
// When a frame is driven, the bench pushes its expected {parity_error,
// framing_error, data_out} to a per-device queue. A negedge monitor pops that
// queue on every data_valid pulse and compares the outputs with it.

module tb_uart_rx_frame_checker;

  logic       clk;
  logic       rst_n;
  logic       bv0, bi0, bv1, bi1;
  logic [1:0] parity_mode;
  logic       cnt_clear;

  logic [7:0] do0, do1;
  logic       dv0, pe0, fe0, by0;
  logic       dv1, pe1, fe1, by1;
  logic [7:0] pc0, fc0, pc1, fc1;
  logic [1:0] st0, st1;

  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  int         exp_pc[2];
  int         exp_fc[2];
  int         check_cnt;
  int         pass_cnt;
  int         busy_cnt;

  uart_rx_frame_checker #(.DATA_W(8), .STOP_BITS(1), .CNT_W(8)) dut0 (
    .CLK(clk), .RST(rst_n), .bit_valid(bv0), .bit_in(bi0),
    .parity_mode(parity_mode), .cnt_clear(cnt_clear),
    .data_out(do0), .data_valid(dv0), .parity_error(pe0), .framing_error(fe0),
    .busy(by0), .parity_err_cnt(pc0), .framing_err_cnt(fc0), .fsm_state(st0)
  );

  uart_rx_frame_checker #(.DATA_W(8), .STOP_BITS(2), .CNT_W(8)) dut1 (
    .CLK(clk), .RST(rst_n), .bit_valid(bv1), .bit_in(bi1),
    .parity_mode(parity_mode), .cnt_clear(cnt_clear),
    .data_out(do1), .data_valid(dv1), .parity_error(pe1), .framing_error(fe1),
    .busy(by1), .parity_err_cnt(pc1), .framing_err_cnt(fc1), .fsm_state(st1)
  );

  // Clock and reset: 10 ns clock; reset is driven from the stimulus block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Scoreboard monitor: every data_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    logic [9:0] e;
    if (dv0) begin
      if (exp_q0.size() == 0) chk("dv0_spurious", {31'b0, dv0}, 32'd0);
      else begin
        e = exp_q0.pop_front();
        chk("frame0", {22'b0, pe0, fe0, do0}, {22'b0, e});
      end
    end
    if (dv1) begin
      if (exp_q1.size() == 0) chk("dv1_spurious", {31'b0, dv1}, 32'd0);
      else begin
        e = exp_q1.pop_front();
        chk("frame1", {22'b0, pe1, fe1, do1}, {22'b0, e});
      end
    end
  end

  // Busy span counter used by the gapped-stream check
  always @(negedge clk) begin
    if (by0) busy_cnt++;
  end

  // Driver: present one accepted sample, then idle for gap-1 cycles
  task automatic bit_step(input int sel, input logic b, input int gap);
    if (sel == 0) begin bv0 = 1'b1; bi0 = b; end
    else          begin bv1 = 1'b1; bi1 = b; end
    @(negedge clk);
    bv0 = 1'b0;
    bv1 = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic check_counters(input int sel);
    if (sel == 0) begin
      chk("par_cnt0", {24'b0, pc0}, exp_pc[0]);
      chk("fr_cnt0",  {24'b0, fc0}, exp_fc[0]);
    end else begin
      chk("par_cnt1", {24'b0, pc1}, exp_pc[1]);
      chk("fr_cnt1",  {24'b0, fc1}, exp_fc[1]);
    end
  endtask

  // Driver plus reference model for one complete frame
  task automatic send_frame(input int sel, input logic [7:0] data, input logic [1:0] mode,
                            input logic par_bit, input logic s0, input logic s1,
                            input int gap, input logic clr_last);
    logic       has_par, perr, ferr, last;
    logic [7:0] exp_d;
    logic [1:0] mid_mode;
    int         nstop;
    nstop   = (sel == 0) ? 1 : 2;
    has_par = (mode == 2'b01) || (mode == 2'b10);
    perr    = has_par && (par_bit != ((mode == 2'b10) ? ~(^data) : (^data)));
    ferr    = !s0 || ((nstop == 2) && !s1);
    exp_d   = perr ? 8'h00 : data;
    if (sel == 0) exp_q0.push_back({perr, ferr, exp_d});
    else          exp_q1.push_back({perr, ferr, exp_d});
    if (clr_last) begin
      exp_pc[0] = 0; exp_pc[1] = 0; exp_fc[0] = 0; exp_fc[1] = 0;
    end else begin
      if (perr && exp_pc[sel] < 255) exp_pc[sel]++;
      if (ferr && exp_fc[sel] < 255) exp_fc[sel]++;
    end
    // The mode seen after the start bit toggles parity presence to show it is ignored.
    mid_mode = has_par ? 2'b00 : 2'b01;
    parity_mode = mode;
    bit_step(sel, 1'b0, gap);
    parity_mode = mid_mode;
    for (int i = 0; i < 8; i++) bit_step(sel, data[i], gap);
    if (has_par) bit_step(sel, par_bit, gap);
    if (nstop == 2) begin
      bit_step(sel, s0, gap);
      chk("busy_mid_stop", {31'b0, by1}, 32'd1);
    end
    last = (nstop == 2) ? s1 : s0;
    if (sel == 0) begin bv0 = 1'b1; bi0 = last; end
    else          begin bv1 = 1'b1; bi1 = last; end
    if (clr_last) cnt_clear = 1'b1;
    @(negedge clk);
    bv0 = 1'b0;
    bv1 = 1'b0;
    cnt_clear = 1'b0;
    chk("valid_latency", {31'b0, (sel == 0) ? dv0 : dv1}, 32'd1);
    chk("busy_after",    {31'b0, (sel == 0) ? by0 : by1}, 32'd0);
    repeat (gap - 1) @(negedge clk);
    check_counters(sel);
  endtask

  // Directed stimulus sequence
  initial begin
    logic [7:0] d;
    logic [1:0] m;
    logic       pb, sb;
    check_cnt = 0; pass_cnt = 0; busy_cnt = 0;
    exp_pc[0] = 0; exp_pc[1] = 0; exp_fc[0] = 0; exp_fc[1] = 0;
    rst_n = 1'b0;
    bv0 = 1'b0; bi0 = 1'b1; bv1 = 1'b0; bi1 = 1'b1;
    parity_mode = 2'b00;
    cnt_clear = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_data",  {24'b0, do0}, 32'd0);
    chk("rst_valid", {31'b0, dv0}, 32'd0);
    chk("rst_flags", {30'b0, pe0, fe0}, 32'd0);
    chk("rst_busy",  {31'b0, by0}, 32'd0);
    chk("rst_state", {30'b0, st0}, 32'd0);
    check_counters(0);
    check_counters(1);
    rst_n = 1'b1;
    @(negedge clk);

    // Even parity: clean frame, then wrong parity bit
    send_frame(0, 8'hA5, 2'b01, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    send_frame(0, 8'hA5, 2'b01, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    // Odd parity, correct bit, bad stop
    send_frame(0, 8'h03, 2'b10, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    // Both errors in one frame
    send_frame(0, 8'h01, 2'b01, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    // Mode 11 carries no parity slot
    send_frame(0, 8'h3C, 2'b11, 1'b0, 1'b1, 1'b1, 1, 1'b0);

    // Two stop bits: error only in the second sample, then in the first, then clean
    send_frame(1, 8'h03, 2'b10, 1'b1, 1'b1, 1'b0, 1, 1'b0);
    send_frame(1, 8'hC7, 2'b00, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    send_frame(1, 8'h96, 2'b01, 1'b0, 1'b1, 1'b1, 1, 1'b0);

    // Sparse sample stream, one sample every 16 cycles
    busy_cnt = 0;
    send_frame(0, 8'h5A, 2'b00, 1'b0, 1'b1, 1'b1, 16, 1'b0);
    chk("busy_span", busy_cnt, 32'd144);

    // Reset in the middle of a frame aborts it
    parity_mode = 2'b01;
    bit_step(0, 1'b0, 1);
    for (int i = 0; i < 4; i++) bit_step(0, 1'b1, 1);
    chk("busy_before_abort", {31'b0, by0}, 32'd1);
    rst_n = 1'b0;
    exp_pc[0] = 0; exp_pc[1] = 0; exp_fc[0] = 0; exp_fc[1] = 0;
    @(negedge clk);
    chk("abort_busy",  {31'b0, by0}, 32'd0);
    chk("abort_state", {30'b0, st0}, 32'd0);
    chk("abort_data",  {24'b0, do0}, 32'd0);
    check_counters(0);
    check_counters(1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(0, 8'h81, 2'b01, 1'b0, 1'b1, 1'b1, 1, 1'b0);

    // Randomised frames with random mode, parity and stop, at varied sample rates
    for (int k = 0; k < 24; k++) begin
      d  = 8'($urandom_range(0, 255));
      m  = 2'($urandom_range(0, 3));
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 3) != 0);
      send_frame(0, d, m, pb, sb, 1'b1, $urandom_range(1, 3), 1'b0);
    end

    // Saturate the parity counter, then clear on the same edge as another error
    for (int k = 0; k < 300; k++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(0, d, 2'b01, ~(^d), 1'b1, 1'b1, 1, 1'b0);
    end
    chk("par_cnt_saturated", {24'b0, pc0}, 32'd255);
    send_frame(0, 8'h11, 2'b01, 1'b1, 1'b1, 1'b1, 1, 1'b1);
    chk("par_cnt_cleared", {24'b0, pc0}, 32'd0);

    repeat (4) @(negedge clk);
    chk("queue0_drained", exp_q0.size(), 32'd0);
    chk("queue1_drained", exp_q1.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_checker.md
Name: uart_rx_frame_checker

Overview:
- Parametrised successor to the UART receive parity checker.
- Consumes the mid-bit sample stream from the RX baud sampler and assembles one complete frame: start bit, DATA_W data bits LSB first, an optional parity bit, then STOP_BITS stop bits.
- Checks parity against a runtime-selectable mode and checks every stop bit for framing.
- Presents the received word with a one-cycle valid strobe and per-frame error flags, and keeps saturating error counters for the status registers.

Parameters:
- DATA_W, 8, number of data bits per frame; legal range 5-9.
- STOP_BITS, 1, number of stop bits checked; legal values 1 or 2.
- CNT_W, 8, width of each saturating error counter.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- bit_valid  input  1  one-cycle strobe; bit_in is a valid mid-bit sample.
- bit_in  input  1  sampled RX line value.
- parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
- cnt_clear  input  1  synchronous clear of both error counters.
- data_out  output  DATA_W  received word; zero when the frame has a parity error.
- data_valid  output  1  one-cycle pulse when a frame completes.
- parity_error  output  1  parity flag of the completed frame; valid with data_valid.
- framing_error  output  1  stop-bit flag of the completed frame; valid with data_valid.
- busy  output  1  high whenever the FSM is not in IDLE.
- parity_err_cnt  output  CNT_W  saturating count of frames with a parity error.
- framing_err_cnt  output  CNT_W  saturating count of frames with a framing error.

Behaviour:
- Reset (RST low, asynchronous): FSM goes to IDLE; shift register, bit counter and all outputs go to 0, including both counters.
- Only cycles with bit_valid=1 advance the FSM. bit_valid=0 cycles hold all state.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE:
  - bit_valid=1 with bit_in=0 is the start bit: latch parity_mode into mode_q, clear the bit counter, go to DATA.
  - bit_valid=1 with bit_in=1 is line idle: stay in IDLE.
- DATA:
  - Each accepted sample shifts in LSB first (first data bit lands at data_out[0]).
  - After DATA_W samples: go to PARITY if mode_q is 01 or 10, otherwise go to STOP.
- PARITY:
  - One sample is accepted as the received parity bit.
  - Even mode expects received bit = XOR of the data bits.
  - Odd mode expects received bit = NOT XOR of the data bits.
  - A mismatch sets par_err_q. Then go to STOP.
- STOP:
  - Accepts STOP_BITS samples. Any sample equal to 0 sets fr_err_q.
  - After the last stop sample, return to IDLE.
  - No early exit on a bad stop bit; the full STOP_BITS samples are always consumed.
- Completion, on the CLK edge that accepts the last stop sample:
  - data_valid=1 for exactly one cycle.
  - data_out = par_err_q ? 0 : shifted word.
  - parity_error and framing_error registered from the frame flags. Both may be 1 together.
- data_out and the error flags hold their values until the next completion.
- Latency: outputs are visible in the cycle after the final stop sample edge. No back-pressure; the consumer must take data on data_valid.
- busy is 1 from the start-bit edge up to and including the final stop edge, then returns to 0.
- parity_mode changes mid-frame have no effect; mode_q is frozen per frame.
- Counters:
  - Each increments by 1 on a completion with its flag set and saturates at all-ones.
  - cnt_clear=1 zeroes both counters. It takes priority over a simultaneous increment on the same edge.
- Reset asserted mid-frame aborts the frame with no data_valid. After release the FSM waits in IDLE for a new start bit.
- Back-to-back frames: a start bit sampled on the bit_valid immediately after the last stop sample is accepted normally.

Test Plan:
- DATA_W=8, STOP_BITS=1, mode 01 (even), frame 0xA5 with parity bit 0 and stop 1 -> one data_valid pulse, data_out=0xA5, parity_error=0, framing_error=0, counters unchanged.
- Same frame with parity bit 1 -> data_out=0x00, parity_error=1, parity_err_cnt 0->1.
- Mode 10 (odd), frame 0x03 with parity bit 1, stop 0 -> data_out=0x03, parity_error=0, framing_error=1, framing_err_cnt increments; with STOP_BITS=2 and stop bits 1,0 -> framing_error=1 after the second stop sample only.
- Mode 00, frame 0x5A with no parity slot, stop 1, bit_valid gapped 1-in-16 -> data_out=0x5A one cycle after the 10th accepted sample; busy high for exactly that span.
- Assert RST after 4 data bits, release, send a fresh frame 0x81 -> no output pulse for the aborted frame; the next frame gives data_out=0x81.
- Drive 300 parity-error frames with CNT_W=8 -> parity_err_cnt saturates at 0xFF; cnt_clear on the same edge as a 301st error -> counter reads 0.
